// File: rtl/alu_result_stage.sv
// Two-entry result FIFO that derives {N,Z,C,V}, drops nops and accumulates sticky flags.
// Latency: one cycle into an empty queue. in_ready depends only on occupancy, never on out_ready.
module alu_result_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  control,
  input  logic [31:0] bus_in,
  input  logic        c_in,
  input  logic        v_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags,
  output logic [3:0]  sticky_flags,
  input  logic        clr_sticky,
  output logic [1:0]  count
);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  flags;
  } entry_t;

  entry_t     mem [2];
  logic       wrPtr;
  logic       rdPtr;
  logic       doEnq;
  logic       doDeq;
  logic [3:0] newFlags;
  entry_t     headEntry;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);

  assign newFlags = {bus_in[31], (bus_in == 32'h0), c_in, v_in};
  // Nops finish the handshake but never occupy a slot.
  assign doEnq    = in_valid && in_ready && (control != 3'b000);
  assign doDeq    = out_valid && out_ready;

  assign headEntry = mem[rdPtr];
  assign out_data  = out_valid ? headEntry.data  : 32'h0;
  assign out_flags = out_valid ? headEntry.flags : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]       <= '0;
      mem[1]       <= '0;
      wrPtr        <= 1'b0;
      rdPtr        <= 1'b0;
      count        <= 2'd0;
      sticky_flags <= 4'h0;
    end else begin
      if (doEnq) begin
        mem[wrPtr] <= '{data: bus_in, flags: newFlags};
        wrPtr      <= ~wrPtr;
      end
      if (doDeq) begin
        rdPtr <= ~rdPtr;
      end

      case ({doEnq, doDeq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // A clear coinciding with an enqueue keeps only the new entry's flags.
      if (clr_sticky) begin
        sticky_flags <= doEnq ? newFlags : 4'h0;
      end else if (doEnq) begin
        sticky_flags <= sticky_flags | newFlags;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: a negedge monitor tracks a queue model, directed cases hit the corner behaviour.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  control;
  logic [31:0] bus_in;
  logic        c_in;
  logic        v_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [3:0]  sticky_flags;
  logic        clr_sticky;
  logic [1:0]  count;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;
  } ent_t;

  ent_t       expQ [$];
  logic [3:0] modelSticky = 4'h0;
  bit         armed = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .control      (control),
    .bus_in       (bus_in),
    .c_in         (c_in),
    .v_in         (v_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] ctl, input logic [31:0] d,
                       input logic c, input logic ov, input logic rdy, input logic clr);
    in_valid   = v;
    control    = ctl;
    bus_in     = d;
    c_in       = c;
    v_in       = ov;
    out_ready  = rdy;
    clr_sticky = clr;
  endtask

  // Model observes the settled inputs half a cycle before the edge that acts on them.
  always @(negedge clk) begin
    logic       acc;
    logic       enq;
    logic       deq;
    logic [3:0] nf;
    if (armed) begin
      chk("mon_count", 32'(count), 32'(expQ.size()));
      chk("mon_in_ready", 32'(in_ready), 32'(expQ.size() < 2));
      chk("mon_out_valid", 32'(out_valid), 32'(expQ.size() > 0));
      chk("mon_sticky", 32'(sticky_flags), 32'(modelSticky));
      if (expQ.size() > 0) begin
        chk("mon_head_data", out_data, expQ[0].d);
        chk("mon_head_flags", 32'(out_flags), 32'(expQ[0].f));
      end else begin
        chk("mon_idle_data", out_data, 32'h0);
        chk("mon_idle_flags", 32'(out_flags), 32'h0);
      end
    end
    if (!rst_n) begin
      expQ.delete();
      modelSticky = 4'h0;
      armed = 1'b1;
    end else if (armed) begin
      acc = in_valid && (expQ.size() < 2);
      enq = acc && (control != 3'b000);
      deq = (expQ.size() > 0) && out_ready;
      nf  = {bus_in[31], (bus_in == 32'h0), c_in, v_in};
      if (deq) void'(expQ.pop_front());
      if (enq) expQ.push_back('{d: bus_in, f: nf});
      if (clr_sticky) modelSticky = enq ? nf : 4'h0;
      else if (enq)   modelSticky = modelSticky | nf;
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_out_data", out_data, 32'h0);

    // zero result with carry
    drive(1'b1, 3'b001, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero_out_valid", 32'(out_valid), 32'd1);
    chk("zero_out_data", out_data, 32'h0);
    chk("zero_out_flags", 32'(out_flags), 32'b0110);
    chk("zero_sticky", 32'(sticky_flags), 32'b0110);
    chk("zero_count", 32'(count), 32'd1);
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_count", 32'(count), 32'd0);
    chk("clr_sticky_alone", 32'(sticky_flags), 32'd0);

    // fill to two, then a third push that must be refused
    drive(1'b1, 3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b011, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_data", out_data, 32'h8000_0000);
    chk("full_head_flags", 32'(out_flags), 32'b1001);
    drive(1'b1, 3'b001, 32'h99, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_push_count", 32'(count), 32'd1);
    chk("second_head_data", out_data, 32'h5);
    chk("second_head_flags", 32'(out_flags), 32'b0000);

    // enqueue and consume together at one entry
    drive(1'b1, 3'b001, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("swap_count", 32'(count), 32'd1);
    chk("swap_head_data", out_data, 32'h7);

    // nop
    drive(1'b1, 3'b000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nop_count", 32'(count), 32'd1);
    chk("nop_sticky", 32'(sticky_flags), 32'b1001);

    // clear together with a push of zero
    drive(1'b1, 3'b001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_push_sticky", 32'(sticky_flags), 32'b0100);
    chk("clr_push_count", 32'(count), 32'd2);
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_only_sticky", 32'(sticky_flags), 32'd0);

    // reset while full with both handshakes requested
    drive(1'b1, 3'b001, 32'h3, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("sync_rst_hold_count", 32'(count), 32'd2);
    step();
    rst_n = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // random traffic, the monitor does the checking
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = 32'h0;
        1:       d = 32'h8000_0000 | $urandom();
        default: d = $urandom();
      endcase
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), d,
            1'($urandom()), 1'($urandom()), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) == 0));
      step();
    end

    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10 && out_valid; i++) step();
    chk("final_drained", 32'(out_valid), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
